// File: rtl/ann_pkg.sv
// rtl/ann_pkg.sv - shared types, default sizes and sequencer states for the layer front-end
//
// Purpose: common definitions imported by pixel_buffer and layer_sequencer.
//   word_t       : one Q8.8 pixel / activation word
//   DEF_*        : default image length and node count
//   CNT_W        : width of the MAC step index (covers images up to 128 pixels)
//   seq_state_t  : sequencer phases for one layer pass
package ann_pkg;

  typedef logic [15:0] word_t;

  localparam int DEF_IMAGE_SIZE = 64;
  localparam int DEF_NUM_NODES  = 10;
  localparam int CNT_W          = 7;

  typedef enum logic [2:0] {
    LOAD,
    CLEAR,
    ACCUM,
    CAPTURE,
    DONE
  } seq_state_t;

endpackage

// File: rtl/pixel_buffer.sv
// rtl/pixel_buffer.sv - image store with single write port and full parallel read
//
// Purpose: holds one image so every node can see all pixels at once.
// Ports:
//   clk       in   system clock
//   n_rst     in   asynchronous active-low clear of every entry
//   we        in   write enable
//   idx       in   write index (CNT_W bits)
//   data      in   word written at idx
//   data_out  out  all IMAGE_SIZE entries in parallel
module pixel_buffer
  import ann_pkg::*;
#(
  parameter int IMAGE_SIZE = DEF_IMAGE_SIZE
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   we,
  input  logic [CNT_W-1:0]       idx,
  input  word_t                  data,
  output word_t [IMAGE_SIZE-1:0] data_out
);

  word_t [IMAGE_SIZE-1:0] r_mem;

  // Decode the index by comparison so the index width need not match the depth.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_mem <= '0;
    end else if (we) begin
      for (int i = 0; i < IMAGE_SIZE; i++) begin
        if (idx == CNT_W'(i)) begin
          r_mem[i] <= data;
        end
      end
    end
  end

  assign data_out = r_mem;

endmodule

// File: rtl/layer_sequencer.sv
// rtl/layer_sequencer.sv - front-end controller for one fully-connected layer pass
//
// Purpose: loads one streamed image, drives node control through a full MAC pass,
// captures all node outputs and offers them downstream with valid/ready.
// Ports:
//   clk, n_rst            clock, asynchronous active-low reset
//   abort                 synchronous flush back to LOAD (buffer/result kept)
//   pix_valid/pix_data    upstream pixel stream, pix_ready back-pressure
//   data_out              buffered image to node data_in
//   cnt_val/start/reset_acc  node control: step index, hold (1) / accumulate (0), clear
//   node_res              node outputs
//   layer_out/out_valid/out_ready  latched activations and handshake
//   busy                  high while clearing, accumulating or capturing
module layer_sequencer
  import ann_pkg::*;
#(
  parameter int IMAGE_SIZE = DEF_IMAGE_SIZE,
  parameter int NUM_NODES  = DEF_NUM_NODES
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   abort,
  input  logic                   pix_valid,
  input  word_t                  pix_data,
  output logic                   pix_ready,
  output word_t [IMAGE_SIZE-1:0] data_out,
  output logic [CNT_W-1:0]       cnt_val,
  output logic                   start,
  output logic                   reset_acc,
  input  word_t [NUM_NODES-1:0]  node_res,
  output word_t [NUM_NODES-1:0]  layer_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(IMAGE_SIZE - 1);

  seq_state_t             r_state;
  seq_state_t             w_next_state;
  logic [CNT_W-1:0]       r_wr_idx;
  logic [CNT_W-1:0]       r_step;
  word_t [NUM_NODES-1:0]  r_layer_out;
  logic                   r_out_valid;
  logic                   w_beat;

  // A beat coinciding with abort is dropped so the flushed image starts clean.
  assign w_beat = (r_state == LOAD) && pix_valid && !abort;

  pixel_buffer #(
    .IMAGE_SIZE(IMAGE_SIZE)
  ) u_pixel_buffer (
    .clk      (clk),
    .n_rst    (n_rst),
    .we       (w_beat),
    .idx      (r_wr_idx),
    .data     (pix_data),
    .data_out (data_out)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= LOAD;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Node control is decoded from the state register only, never from inputs.
  always_comb begin
    w_next_state = r_state;
    pix_ready    = 1'b0;
    start        = 1'b1;
    reset_acc    = 1'b0;
    cnt_val      = '0;
    busy         = 1'b0;
    unique case (r_state)
      LOAD: begin
        pix_ready = 1'b1;
        if (w_beat && (r_wr_idx == LAST)) begin
          w_next_state = CLEAR;
        end
      end
      CLEAR: begin
        reset_acc    = 1'b1;
        busy         = 1'b1;
        w_next_state = ACCUM;
      end
      ACCUM: begin
        start   = 1'b0;
        cnt_val = r_step;
        busy    = 1'b1;
        if (r_step == LAST) begin
          w_next_state = CAPTURE;
        end
      end
      CAPTURE: begin
        busy         = 1'b1;
        w_next_state = DONE;
      end
      DONE: begin
        if (out_ready) begin
          w_next_state = LOAD;
        end
      end
      default: begin
        w_next_state = LOAD;
      end
    endcase
    if (abort) begin
      w_next_state = LOAD;
    end
  end

  // Both counters return to zero on their last value instead of wrapping.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_wr_idx <= '0;
      r_step   <= '0;
    end else if (abort) begin
      r_wr_idx <= '0;
      r_step   <= '0;
    end else begin
      if (w_beat) begin
        r_wr_idx <= (r_wr_idx == LAST) ? '0 : r_wr_idx + CNT_W'(1);
      end
      if ((r_state == ACCUM) && (r_step != LAST)) begin
        r_step <= r_step + CNT_W'(1);
      end else begin
        r_step <= '0;
      end
    end
  end

  // An abort during CAPTURE leaves the previous result in place.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_layer_out <= '0;
      r_out_valid <= 1'b0;
    end else if (abort) begin
      r_out_valid <= 1'b0;
    end else if (r_state == CAPTURE) begin
      r_layer_out <= node_res;
      r_out_valid <= 1'b1;
    end else if ((r_state == DONE) && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign layer_out = r_layer_out;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_layer_sequencer.sv
// tb/tb_layer_sequencer.sv - scoreboard bench for layer_sequencer with a golden node model
module tb_layer_sequencer;
  import ann_pkg::*;

  localparam int IS = 64;
  localparam int NN = 10;
  localparam int VW = NN * 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              n_rst, abort, pix_valid, pix_ready;
  logic              start, reset_acc, out_valid, out_ready, busy;
  word_t             pix_data;
  word_t [IS-1:0]    data_out;
  logic [CNT_W-1:0]  cnt_val;
  word_t [NN-1:0]    node_res, layer_out;

  layer_sequencer #(.IMAGE_SIZE(IS), .NUM_NODES(NN)) dut (
    .clk(clk), .n_rst(n_rst), .abort(abort), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_ready(pix_ready), .data_out(data_out), .cnt_val(cnt_val), .start(start),
    .reset_acc(reset_acc), .node_res(node_res), .layer_out(layer_out),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  word_t          coef [NN][IS];
  word_t          acc  [NN];
  logic           force_mode = 1'b0;
  word_t          force_xor  = '0;
  logic [VW-1:0]  exp_q [$];
  int             cidx;

  function automatic word_t qmul(input word_t a, input word_t b);
    logic signed [31:0] p;
    p = $signed(a) * $signed(b);
    return p[23:8];
  endfunction

  function automatic logic [VW-1:0] golden(input word_t img [IS]);
    word_t [NN-1:0] r;
    word_t s;
    for (int i = 0; i < NN; i++) begin
      s = '0;
      for (int k = 0; k < IS; k++) s = s + qmul(coef[i][k], img[k]);
      r[i] = s;
    end
    return r;
  endfunction

  function automatic logic [VW-1:0] pattern();
    word_t [NN-1:0] r;
    for (int i = 0; i < NN; i++) r[i] = word_t'(i * 256);
    return r;
  endfunction

  // Node instances: clear on reset_acc, accumulate coef*data at step cnt_val when start=0.
  always_comb cidx = int'(cnt_val);
  always @(posedge clk) begin
    for (int i = 0; i < NN; i++) begin
      if (reset_acc) acc[i] <= '0;
      else if (!start) acc[i] <= acc[i] + qmul(coef[i][cidx], data_out[cidx]);
    end
  end
  always_comb begin
    for (int i = 0; i < NN; i++)
      node_res[i] = force_mode ? (word_t'(i * 256) ^ force_xor) : acc[i];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic chk_vec(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  task automatic chk_img(input string nm, input word_t img [IS]);
    int bad;
    bad = -1;
    for (int k = IS - 1; k >= 0; k--) if (data_out[k] !== img[k]) bad = k;
    n_cmp++;
    if (bad >= 0) begin
      n_bad++;
      $display("FAIL %s: data_out[%0d]=%h expected %h", nm, bad, data_out[bad], img[bad]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted output is popped against the scoreboard.
  initial begin
    logic [VW-1:0] e;
    forever begin
      @(negedge clk);
      if (n_rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_output: got %h with empty scoreboard", layer_out);
        end else begin
          e = exp_q.pop_front();
          chk_vec("layer_out", layer_out, e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_image(input word_t img [IS], input int pct);
    int  k, cyc;
    bit  fire, early;
    k = 0; cyc = 0; early = 0;
    while (k < IS && cyc < 4000) begin
      pix_valid = ($urandom_range(99) < pct);
      pix_data  = img[k];
      @(negedge clk);
      fire = pix_valid && pix_ready;
      if (!pix_ready) early = 1;
      tick();
      if (fire) k++;
      cyc++;
    end
    pix_valid = 1'b0;
    chk("load_beats", 64'(k), 64'(IS));
    chk("pix_ready_during_load", 64'(early), 64'(0));
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < budget) begin
      tick();
      @(negedge clk);
      n++;
    end
    chk("out_valid_timeout", 64'(out_valid), 64'(1));
    repeat ($urandom_range(3)) tick();
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    word_t img  [IS];
    word_t img2 [IS];
    int    n;
    bit    seen;

    n_rst = 1'b0; abort = 1'b0; pix_valid = 1'b0; pix_data = '0; out_ready = 1'b0;
    for (int i = 0; i < NN; i++)
      for (int k = 0; k < IS; k++) coef[i][k] = word_t'($urandom);

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_start", 64'(start), 64'(1));
    chk("rst_reset_acc", 64'(reset_acc), 64'(0));
    chk("rst_cnt_val", 64'(cnt_val), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk_vec("rst_layer_out", layer_out, '0);
    chk("rst_buffer", 64'(data_out[IS-1]), 64'(0));
    tick();
    n_rst = 1'b1;
    @(negedge clk);
    chk("rst_pix_ready", 64'(pix_ready), 64'(1));

    // Reset in the middle of a pass
    tick();
    for (int k = 0; k < IS; k++) img[k] = word_t'($urandom);
    send_image(img, 100);
    repeat (20) tick();
    @(negedge clk);
    chk("mid_accum_start", 64'(start), 64'(0));
    tick();
    n_rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_start", 64'(start), 64'(1));
    chk("midrst_reset_acc", 64'(reset_acc), 64'(0));
    chk("midrst_cnt_val", 64'(cnt_val), 64'(0));
    chk("midrst_pix_ready", 64'(pix_ready), 64'(1));
    chk("midrst_buffer", 64'(data_out[5]), 64'(0));
    tick();
    n_rst = 1'b1;
    seen = 0;
    repeat (IS + 10) begin
      @(negedge clk);
      seen |= out_valid;
      tick();
    end
    chk("no_partial_output", 64'(seen), 64'(0));

    // Ramp image, full latency profile
    for (int k = 0; k < IS; k++) img[k] = word_t'(k);
    exp_q.push_back(golden(img));
    send_image(img, 100);
    @(negedge clk);
    chk("t1_reset_acc", 64'(reset_acc), 64'(1));
    chk("t1_start", 64'(start), 64'(1));
    chk("t1_pix_ready", 64'(pix_ready), 64'(0));
    for (int s = 0; s < IS; s++) begin
      tick();
      @(negedge clk);
      chk("accum_cnt_val", 64'(cnt_val), 64'(s));
      chk("accum_ctrl", {62'd0, start, reset_acc}, 64'(0));
    end
    tick();
    @(negedge clk);
    chk("capture_out_valid", 64'(out_valid), 64'(0));
    chk("capture_start", 64'(start), 64'(1));
    tick();
    @(negedge clk);
    chk("t67_out_valid", 64'(out_valid), 64'(1));
    chk_img("ramp_buffer", img);
    drain(10);

    // Fixed node pattern, change in DONE, back-pressure and writes ignored in DONE
    force_mode = 1'b1;
    force_xor  = '0;
    for (int k = 0; k < IS; k++) img[k] = word_t'($urandom);
    exp_q.push_back(pattern());
    send_image(img, 50);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 200) begin
      tick();
      @(negedge clk);
      n++;
    end
    chk("pattern_done", 64'(out_valid), 64'(1));
    tick();
    force_xor = 16'hFFFF;
    pix_valid = 1'b1;
    pix_data  = 16'hBEEF;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c % 5 == 0) begin
        chk("hold_out_valid", 64'(out_valid), 64'(1));
        chk_vec("hold_layer_out", layer_out, pattern());
        chk("hold_pix_ready", 64'(pix_ready), 64'(0));
      end
      tick();
    end
    pix_valid = 1'b0;
    chk_img("done_no_writes", img);
    drain(5);
    @(negedge clk);
    chk("after_hs_out_valid", 64'(out_valid), 64'(0));
    chk("after_hs_pix_ready", 64'(pix_ready), 64'(1));
    tick();
    force_mode = 1'b0;

    // Random images with 50% pix_valid against the golden node model
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < IS; k++) img[k] = word_t'($urandom);
      exp_q.push_back(golden(img));
      send_image(img, 50);
      chk_img("random_buffer", img);
      drain(200);
    end

    // Abort at step 30, beat during abort dropped, fresh image afterwards
    for (int k = 0; k < IS; k++) img[k] = word_t'($urandom);
    send_image(img, 100);
    n = 0;
    @(negedge clk);
    while (!(busy && !start && cnt_val == 29) && n < 200) begin
      tick();
      @(negedge clk);
      n++;
    end
    chk("reach_step29", 64'(cnt_val), 64'(29));
    tick();
    abort     = 1'b1;
    pix_valid = 1'b1;
    pix_data  = 16'hDEAD;
    @(negedge clk);
    chk("abort_at_step30", 64'(cnt_val), 64'(30));
    tick();
    @(negedge clk);
    chk("abort_pix_ready", 64'(pix_ready), 64'(1));
    chk("abort_start", 64'(start), 64'(1));
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_cnt_val", 64'(cnt_val), 64'(0));
    chk("abort_out_valid", 64'(out_valid), 64'(0));
    tick();
    abort     = 1'b0;
    pix_valid = 1'b0;
    chk_img("abort_keeps_buffer", img);
    for (int k = 0; k < IS; k++) img2[k] = word_t'($urandom);
    exp_q.push_back(golden(img2));
    send_image(img2, 50);
    chk_img("post_abort_buffer", img2);
    drain(200);

    repeat (5) tick();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
